// File: rtl/nanci_phase_ctrl.sv
// Purpose : phase sequencer for an N x N shear-sort mesh; runs ROW/COL odd-even transposition phases.
// Latency : o_load one cycle after i_start is sampled in IDLE; o_done (2*ITERS-1)*N*SORT_CYCLES + 1 cycles after o_load.
// Backpr. : i_hold freezes state, counters and o_cycles, and masks o_load/o_step_en/o_done for as long as it is high.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   i_start   - run request, honoured only in IDLE
//   i_hold    - stall
//   o_load    - one-cycle "latch fresh data" pulse to the PEs
//   o_phase   - 00 idle, 01 row phase, 10 column phase
//   o_odd     - parity of the current transposition step
//   o_step_en - compare-exchange commit strobe (last cycle of each step)
//   o_busy    - high from LOAD through the last sort cycle
//   o_done    - one-cycle completion pulse
//   o_cycles  - busy-cycle count; live only when NANCI_PHASE_STATS_EN is defined, else tied to 0
module nanci_phase_ctrl #(
    parameter int N           = 4,
    parameter int SORT_CYCLES = 1,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_hold,
    output logic          o_load,
    output logic [1:0]    o_phase,
    output logic          o_odd,
    output logic          o_step_en,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_cycles
);

    localparam int ITERS = $clog2(N) + 1;
    localparam int SW    = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int CSW   = ($clog2(SORT_CYCLES) > 1) ? $clog2(SORT_CYCLES) : 1;
    localparam int PW    = $clog2(2 * ITERS);

    localparam logic [SW-1:0]  STEP_LAST = SW'(N - 1);
    localparam logic [CSW-1:0] SUB_LAST  = CSW'(SORT_CYCLES - 1);
    localparam logic [PW-1:0]  PH_LAST   = PW'(2 * ITERS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROW,
        S_COL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  step_q, step_d;
    logic [CSW-1:0] sub_q, sub_d;
    logic [PW-1:0]  ph_q, ph_d;

    // Output flops, all derived from the next-state values.
    logic       load_q, load_d;
    logic       done_q, done_d;
    logic       step_en_q, step_en_d;
    logic       busy_q, busy_d;
    logic       odd_q, odd_d;
    logic [1:0] phase_q, phase_d;

    logic [PW-1:0] ph_nxt;
    logic          sorting_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sub_d   = sub_q;
        ph_d    = ph_q;
        ph_nxt  = ph_q + 1'b1;

        if (!i_hold) begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_d = S_ROW;
                    step_d  = '0;
                    sub_d   = '0;
                    ph_d    = '0;
                end
                S_ROW, S_COL: begin
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (step_q == STEP_LAST) begin
                            step_d = '0;
                            if (ph_q == PH_LAST) begin
                                state_d = S_DONE;
                                ph_d    = '0;
                            end else begin
                                // Even phase index = row phase, odd = column phase.
                                ph_d    = ph_nxt;
                                state_d = ph_nxt[0] ? S_COL : S_ROW;
                            end
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        sorting_d = (state_d == S_ROW) || (state_d == S_COL);
        load_d    = (state_d == S_LOAD);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d == S_LOAD) || sorting_d;
        step_en_d = sorting_d && (sub_d == SUB_LAST);
        odd_d     = sorting_d && step_d[0];
        phase_d   = (state_d == S_ROW) ? 2'b01 :
                    (state_d == S_COL) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            sub_q     <= '0;
            ph_q      <= '0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            step_en_q <= 1'b0;
            busy_q    <= 1'b0;
            odd_q     <= 1'b0;
            phase_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            sub_q     <= sub_d;
            ph_q      <= ph_d;
            load_q    <= load_d;
            done_q    <= done_d;
            step_en_q <= step_en_d;
            busy_q    <= busy_d;
            odd_q     <= odd_d;
            phase_q   <= phase_d;
        end
    end

    // Strobes are masked straight from i_hold so a stalled cycle never commits;
    // the underlying flops keep their value and the pulse appears once released.
    assign o_load    = load_q & ~i_hold;
    assign o_done    = done_q & ~i_hold;
    assign o_step_en = step_en_q & ~i_hold;
    assign o_busy    = busy_q;
    assign o_odd     = odd_q;
    assign o_phase   = phase_q;

`ifdef NANCI_PHASE_STATS_EN
    logic [CW-1:0] cycles_q, cycles_d;

    // Cleared on the edge into LOAD, counts every unheld busy cycle, saturates,
    // and keeps the last run's total through DONE and IDLE.
    always_comb begin
        cycles_d = cycles_q;
        if (!i_hold) begin
            if ((state_q == S_IDLE) && i_start) begin
                cycles_d = '0;
            end else if (busy_q && (cycles_q != '1)) begin
                cycles_d = cycles_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign o_cycles = cycles_q;
`else
    assign o_cycles = '0;
`endif

endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// Purpose : directed bench for nanci_phase_ctrl using per-cycle expected traces in scoreboard queues.
// Latency : expectations are pushed in the cycle they apply to and popped on the falling edge.
// Backpr. : i_hold windows are part of each generated trace, frozen outputs are expected for them.
module tb_nanci_phase_ctrl;

    typedef struct packed {
        logic        load;
        logic [1:0]  phase;
        logic        odd;
        logic        step_en;
        logic        busy;
        logic        done;
        logic [15:0] cycles;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v   = 3'b000;
    logic [2:0] start_v = 3'b000;
    logic [2:0] hold_v  = 3'b000;

    logic        load_a, odd_a, sten_a, busy_a, done_a;
    logic [1:0]  phase_a;
    logic [15:0] cyc_a;
    logic        load_b, odd_b, sten_b, busy_b, done_b;
    logic [1:0]  phase_b;
    logic [15:0] cyc_b;
    logic        load_c, odd_c, sten_c, busy_c, done_c;
    logic [1:0]  phase_c;
    logic [15:0] cyc_c;

    nanci_phase_ctrl #(.N(4), .SORT_CYCLES(1), .CW(16)) u_dut_a (
        .clk(clk), .rst(rst_v[0]), .i_start(start_v[0]), .i_hold(hold_v[0]),
        .o_load(load_a), .o_phase(phase_a), .o_odd(odd_a), .o_step_en(sten_a),
        .o_busy(busy_a), .o_done(done_a), .o_cycles(cyc_a)
    );

    nanci_phase_ctrl #(.N(4), .SORT_CYCLES(3), .CW(16)) u_dut_b (
        .clk(clk), .rst(rst_v[1]), .i_start(start_v[1]), .i_hold(hold_v[1]),
        .o_load(load_b), .o_phase(phase_b), .o_odd(odd_b), .o_step_en(sten_b),
        .o_busy(busy_b), .o_done(done_b), .o_cycles(cyc_b)
    );

    nanci_phase_ctrl #(.N(2), .SORT_CYCLES(1), .CW(16)) u_dut_c (
        .clk(clk), .rst(rst_v[2]), .i_start(start_v[2]), .i_hold(hold_v[2]),
        .o_load(load_c), .o_phase(phase_c), .o_odd(odd_c), .o_step_en(sten_c),
        .o_busy(busy_c), .o_done(done_c), .o_cycles(cyc_c)
    );

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {load_a, phase_a, odd_a, sten_a, busy_a, done_a, cyc_a};
    assign obs_b = {load_b, phase_b, odd_b, sten_b, busy_b, done_b, cyc_b};
    assign obs_c = {load_c, phase_c, odd_c, sten_c, busy_c, done_c, cyc_c};

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];

    // Scratch trace built by build_trace, with a parallel i_hold pattern.
    obs_t tr[$];
    bit   trh[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          strobes_b = 0;
    logic [15:0] last_cyc;

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed ld=%b ph=%b odd=%b sten=%b busy=%b done=%b cyc=%0d, expected ld=%b ph=%b odd=%b sten=%b busy=%b done=%b cyc=%0d",
                   tag, $time, got.load, got.phase, got.odd, got.step_en, got.busy, got.done, got.cycles,
                   exp.load, exp.phase, exp.odd, exp.step_en, exp.busy, exp.done, exp.cycles);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_assert++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q_a.size() > 0) check("dut_a_trace", obs_a, q_a.pop_front());
        if (q_b.size() > 0) check("dut_b_trace", obs_b, q_b.pop_front());
        if (q_c.size() > 0) check("dut_c_trace", obs_c, q_c.pop_front());
        if (sten_b === 1'b1) strobes_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int w, input obs_t e);
        obs_t m;
        m = e;
`ifndef NANCI_PHASE_STATS_EN
        m.cycles = '0;
`endif
        case (w)
            0: q_a.push_back(m);
            1: q_b.push_back(m);
            default: q_c.push_back(m);
        endcase
    endtask

    // Expected trace for one run: IDLE (start cycle), LOAD, phases, DONE, trailing IDLE.
    // Hold windows of length hl/hbl are inserted in front of raw entries ha/hb.
    task automatic build_trace(input int n, input int sc, input int ha, input int hl,
                               input int hb, input int hbl, input logic [15:0] c0);
        obs_t raw[$];
        obs_t e;
        int   iters;
        logic [15:0] cnt;
        iters = 1;
        for (int v = n; v > 1; v = v / 2) iters++;
        e = '0;
        raw.push_back(e);
        e.load = 1'b1;
        e.busy = 1'b1;
        raw.push_back(e);
        for (int p = 0; p < 2 * iters - 1; p++) begin
            for (int k = 0; k < n; k++) begin
                for (int c = 0; c < sc; c++) begin
                    e = '0;
                    e.busy    = 1'b1;
                    e.phase   = (p % 2 == 0) ? 2'b01 : 2'b10;
                    e.odd     = ((k % 2) == 1);
                    e.step_en = (c == sc - 1);
                    raw.push_back(e);
                end
            end
        end
        e = '0;
        e.done = 1'b1;
        raw.push_back(e);
        e = '0;
        raw.push_back(e);

        tr.delete();
        trh.delete();
        for (int i = 0; i < raw.size(); i++) begin
            if (i == ha || i == hb) begin
                for (int h = 0; h < ((i == ha) ? hl : hbl); h++) begin
                    e = raw[i];
                    e.load    = 1'b0;
                    e.done    = 1'b0;
                    e.step_en = 1'b0;
                    tr.push_back(e);
                    trh.push_back(1'b1);
                end
            end
            tr.push_back(raw[i]);
            trh.push_back(1'b0);
        end

        cnt = c0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].busy && tr[i].phase == 2'b00) cnt = '0;
            tr[i].cycles = cnt;
            if (tr[i].busy && !trh[i]) cnt = cnt + 16'd1;
        end
    endtask

    task automatic drive(input int w, input int from, input int to, input bit start_all);
        for (int k = from; k <= to; k++) begin
            start_v[w] = start_all || (k == 0);
            hold_v[w]  = trh[k];
            push(w, tr[k]);
            tick();
        end
        start_v[w] = 1'b0;
        hold_v[w]  = 1'b0;
    endtask

    initial begin
        // Reset: outputs zero while held in reset and just after release.
        tick();
        for (int w = 0; w < 3; w++) push(w, '0);
        tick();
        for (int w = 0; w < 3; w++) push(w, '0);
        rst_v = 3'b111;
        tick();
        last_cyc = '0;

        // Basic N=4 run: LOAD at 1, ROW/COL 2..21, DONE at 22, 21 busy cycles.
        build_trace(4, 1, -1, 0, -1, 0, last_cyc);
        drive(0, 0, tr.size() - 1, 1'b0);
        last_cyc = tr[tr.size() - 1].cycles;

        // Five-cycle stall starting at cycle 7 (mid column phase).
        build_trace(4, 1, 7, 5, -1, 0, last_cyc);
        drive(0, 0, tr.size() - 1, 1'b0);
        last_cyc = tr[tr.size() - 1].cycles;

        // Stall on LOAD and on DONE: each pulse slips to the first unheld cycle.
        build_trace(4, 1, 1, 2, 22, 2, last_cyc);
        drive(0, 0, tr.size() - 1, 1'b0);
        last_cyc = tr[tr.size() - 1].cycles;

        // Reset at cycle 8 aborts the run; restart at cycle 10.
        build_trace(4, 1, -1, 0, -1, 0, last_cyc);
        drive(0, 0, 7, 1'b0);
        push(0, tr[8]);
        rst_v[0] = 1'b0;
        tick();
        rst_v[0] = 1'b1;
        push(0, '0);
        tick();
        last_cyc = '0;
        build_trace(4, 1, -1, 0, -1, 0, last_cyc);
        drive(0, 0, tr.size() - 1, 1'b0);
        last_cyc = tr[tr.size() - 1].cycles;

        // i_start held high: DONE at 22, IDLE at 23, second LOAD at 24.
        build_trace(4, 1, -1, 0, -1, 0, last_cyc);
        drive(0, 0, 22, 1'b1);
        last_cyc = tr[22].cycles;
        build_trace(4, 1, -1, 0, -1, 0, last_cyc);
        drive(0, 0, 1, 1'b1);
        drive(0, 2, tr.size() - 1, 1'b0);

        // N=4, SORT_CYCLES=3: strobe every third cycle, 20 strobes.
        build_trace(4, 3, -1, 0, -1, 0, 16'd0);
        drive(1, 0, tr.size() - 1, 1'b0);
        check_int("dut_b_strobe_count", strobes_b, 20);

        // N=2: ROW, COL, ROW of two steps, DONE eight cycles after i_start.
        build_trace(2, 1, -1, 0, -1, 0, 16'd0);
        check_int("dut_c_done_offset", tr.size() - 2, 8);
        drive(2, 0, tr.size() - 1, 1'b0);

        repeat (2) tick();
        check_int("q_a_drained", q_a.size(), 0);
        check_int("q_b_drained", q_b.size(), 0);
        check_int("q_c_drained", q_c.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nanci_phase_ctrl.md
NANCI_PHASE_CTRL -- requirements
Module: nanci_phase_ctrl

Interface
REQ-001 Parameter N, default 4: mesh side length in PEs; power of two, N >= 2.
REQ-002 Parameter SORT_CYCLES, default 1: clock cycles per compare-exchange step, >= 1.
REQ-003 Parameter CW, default 16: width of the statistics counter.
REQ-004 Port clk  in  1: single clock, all logic on the rising edge.
REQ-005 Port rst  in  1: synchronous, active-low reset.
REQ-006 Port i_start  in  1: request a sort run; sampled only in IDLE.
REQ-007 Port i_hold  in  1: stall; freezes all counters and state while high.
REQ-008 Port o_load  out  1: one-cycle pulse telling the PEs to latch fresh data.
REQ-009 Port o_phase  out  2: encoding 00 = idle, 01 = row phase, 10 = column phase, 11 = unused.
REQ-010 Port o_odd  out  1: parity of the current odd-even transposition step (0 = even pairs, 1 = odd pairs).
REQ-011 Port o_step_en  out  1: compare-exchange commit strobe to the PEs.
REQ-012 Port o_busy  out  1: high from LOAD through the last sort cycle.
REQ-013 Port o_done  out  1: one-cycle completion pulse.
REQ-014 Port o_cycles  out  CW: busy-cycle count of the last or current run (see Configuration).

Function
REQ-015 States are IDLE, LOAD, ROW, COL and DONE.
REQ-016 IDLE transitions to LOAD on the cycle after i_start=1 is sampled.
REQ-017 LOAD lasts one cycle and transitions to ROW.
REQ-018 Run structure:
- ITERS = clog2(N)+1 row phases, with one column phase between consecutive row phases.
- Sequence: ROW, COL, ROW, ..., ROW; total 2*ITERS-1 phases.
REQ-019 Each phase has exactly N steps; each step lasts SORT_CYCLES cycles.
REQ-020 o_step_en is 1 on the last cycle of each step and 0 otherwise.
REQ-021 o_odd is 0 on the first step of every phase and toggles after each committed step.
REQ-022 After the final step of the last ROW phase, the FSM enters DONE; DONE lasts one cycle with o_done=1, then returns to IDLE.
REQ-023 Outputs per state:
- o_phase = 01 in ROW, 10 in COL, 00 otherwise.
- o_busy = 1 in LOAD, ROW and COL; 0 otherwise.
REQ-024 i_start is ignored in LOAD, ROW, COL and DONE; a new run is accepted only from IDLE.
REQ-025 While i_hold=1:
- state, step counter, sub-cycle counter, o_odd and o_cycles hold their values;
- o_step_en, o_load and o_done are forced to 0.
REQ-026 i_hold asserted during LOAD or DONE delays that state's single cycle; the pulse is issued on the first unheld cycle.
REQ-027 Counter widths:
- step counter is max(1, clog2(N)) bits;
- sub-cycle counter is max(1, clog2(SORT_CYCLES)) bits;
- phase counter is clog2(2*ITERS) bits;
- all counters wrap to 0 at their terminal count; overflow is never observable.

Reset
REQ-028 When rst=0 at a rising edge, the FSM enters IDLE and all counters clear.
REQ-029 During and after reset, all outputs are 0: o_phase = 00, o_odd, o_step_en, o_load, o_busy and o_done are 0, and o_cycles = 0.
REQ-030 Reset mid-run aborts the run with no o_done pulse; i_start sampled on the first cycle with rst=1 is honoured.

Configuration
REQ-031 Macro NANCI_PHASE_STATS_EN controls the statistics counter.
REQ-032 When NANCI_PHASE_STATS_EN is defined, o_cycles behaves as follows:
- clears on LOAD entry;
- increments each unheld busy cycle;
- saturates at 2^CW-1;
- holds its value after DONE until the next LOAD.
REQ-033 When NANCI_PHASE_STATS_EN is undefined, o_cycles is tied to 0 and no counter logic is built.

Verification
REQ-034 N=4, SORT_CYCLES=1; i_start pulsed at cycle 0 -> o_load at cycle 1, ROW 2-5, COL 6-9, ROW 10-13, COL 14-17, ROW 18-21, o_done at cycle 22; o_cycles=21 with STATS_EN defined.
REQ-035 N=4, SORT_CYCLES=3 -> o_step_en every 3rd cycle, 20 strobes in total, o_odd sequence 0,1,0,1 within each phase.
REQ-036 i_hold=1 for 5 cycles starting mid-COL -> outputs frozen, no o_step_en, run ends exactly 5 cycles later than REQ-034.
REQ-037 rst=0 at cycle 8 of a run -> cycle 9 shows all outputs 0 and no o_done; i_start at cycle 10 -> o_load at cycle 11.
REQ-038 i_start held high continuously -> o_done at cycle 22, IDLE at 23, second o_load at cycle 24.
REQ-039 N=2, SORT_CYCLES=1 -> phases ROW, COL, ROW of 2 steps each; o_done 8 cycles after i_start.
